des_round_ctrl: RTL
===================

Name: des_round_ctrl

Overview:
- Sequencing controller for the iterative DES datapath: initial permutation/PC-1 load, 16 Feistel rounds, then the final (IP-inverse) permutation stage.
- Accepts one 64-bit block per transaction over a valid/ready handshake.
- Drives round index and key-schedule shift controls for encrypt or decrypt, pulses the final-permutation stage's start, captures its result and presents it downstream with valid/ready hold.

Parameters:
- NUM_ROUNDS, 16, rounds executed per block (legal 1..16; values below 16 are for reduced-round debug only).
- FP_TIMEOUT, 4, max WAIT_FP cycles allowed for fp_ready before the block is aborted with err.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream block/key valid
- in_ready  out  1  controller can accept a block
- in_decrypt  in  1  mode for the block; latched on accept (1 = decrypt)
- rnd_load  out  1  one-cycle pulse: datapath loads IP(block) into L/R and PC-1(key) into C/D
- rnd_en  out  1  datapath performs one round this cycle
- rnd_num  out  5  current round number 1..NUM_ROUNDS, 0 when not in ROUND
- key_shift  out  2  C/D rotate amount this round (0, 1 or 2)
- key_dir  out  1  rotate direction: 0 = left (encrypt), 1 = right (decrypt)
- fp_start  out  1  one-cycle start pulse to the final-permutation stage (R16 & L16 swap applied by datapath)
- fp_ready  in  1  final-permutation stage result valid
- fp_data  in  64  final-permutation stage result
- out_valid  out  1  result held valid
- out_ready  in  1  downstream accepts result
- out_data  out  64  captured result
- err  out  1  one-cycle pulse on FP timeout
- blk_cnt  out  16  completed-block counter, saturates at 16'hFFFF

Behaviour:
- Reset (rst sampled high at a rising edge):
  - state = IDLE.
  - All outputs 0 except in_ready = 1.
  - out_data = 0, blk_cnt = 0, round and timeout counters = 0.
  - Reset takes priority in every state, including mid-round and while out_valid is high; any in-flight block is discarded.
- All control outputs are registered or decoded from registered state, with no combinational path from any input to any output.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_decrypt into mode, go to LOAD.
- LOAD (1 cycle):
  - rnd_load = 1.
  - Round counter set to 1, go to ROUND.
- ROUND (NUM_ROUNDS cycles):
  - rnd_en = 1, rnd_num = counter, key_dir = mode.
  - Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt: key_shift = S[r].
  - Decrypt: key_shift = 0 for r = 1 and S[18-r] for r = 2..16.
  - When counter = NUM_ROUNDS, go to FP; otherwise increment.
- FP (1 cycle):
  - fp_start = 1, go to WAIT_FP.
  - Timeout counter cleared.
- WAIT_FP:
  - If fp_ready: out_data <= fp_data, blk_cnt += 1 (saturating), go to DONE.
  - Else increment the timeout counter. When it reaches FP_TIMEOUT: err = 1 for one cycle, go to IDLE, no capture, blk_cnt unchanged.
- DONE:
  - out_valid = 1 and out_data stable until out_ready is sampled high; then go to IDLE.
  - out_ready high in the first DONE cycle completes the transfer in that cycle.
  - in_ready = 0 in every state except IDLE, so there is no overlap between blocks.
- Latency, counted from the accept edge (cycle 1 = first cycle after it), with NUM_ROUNDS = 16 and fp_ready one cycle after fp_start:
  - LOAD = cycle 1.
  - ROUND = cycles 2–17.
  - FP = cycle 18.
  - WAIT_FP = cycle 19.
  - out_valid first high in cycle 20.
  - Minimum block-to-block period is 21 cycles.
- Inputs outside their qualifying states are ignored: in_decrypt outside accept, fp_ready outside WAIT_FP, out_ready outside DONE.
- A late fp_ready arriving after a timeout abort is ignored.
- blk_cnt holds at 16'hFFFF once saturated.

Test Plan:
- Reset, then idle -> in_ready = 1, all other outputs 0, blk_cnt = 0; assert rst during ROUND at rnd_num = 7 -> next cycle IDLE, rnd_en = 0, in_ready = 1.
- Encrypt accept with a bench datapath model -> rnd_load in cycle 1; rnd_num 1..16 in cycles 2–17 with key_shift sequence 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 and key_dir = 0; fp_start in cycle 18; out_valid in cycle 20; key 133457799BBCDFF1 with plaintext 0123456789ABCDEF -> out_data = 85E813540F0AB405.
- Decrypt accept, same key, block 85E813540F0AB405 -> key_dir = 1, key_shift 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; out_data = 0123456789ABCDEF.
- Hold out_ready low for 5 cycles in DONE with in_valid high -> out_valid and out_data stable, in_ready = 0; out_ready high -> IDLE next cycle, next block accepted, blk_cnt = 2.
- fp_ready held low -> err pulses exactly once after 4 WAIT_FP cycles, state IDLE, blk_cnt unchanged; fp_ready pulsed afterwards -> no effect.
- Preload blk_cnt to FFFE via repeated blocks (or force) -> two completions leave it at FFFF.

Source files
------------

// File: rtl/des_round_ctrl.sv
// Sequencing controller for an iterative DES datapath: accepts one block,
// loads IP/PC-1, steps NUM_ROUNDS Feistel rounds with the key-schedule
// rotate controls, triggers the final permutation and holds the result.
module des_round_ctrl #(
  parameter int NUM_ROUNDS = 16,
  parameter int FP_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  output logic        rnd_load,
  output logic        rnd_en,
  output logic [4:0]  rnd_num,
  output logic [1:0]  key_shift,
  output logic        key_dir,
  output logic        fp_start,
  input  logic        fp_ready,
  input  logic [63:0] fp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        err,
  output logic [15:0] blk_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FP, WAIT_FP, DONE} state_t;

  localparam int             TW         = $clog2(FP_TIMEOUT + 1);
  localparam logic [TW-1:0]  TO_LAST    = TW'(FP_TIMEOUT - 1);
  localparam logic [4:0]     ROUND_LAST = 5'(NUM_ROUNDS);

  state_t        state;
  state_t        state_nxt;
  logic          mode;
  logic [4:0]    rnd_cnt;
  logic [TW-1:0] to_cnt;
  logic [1:0]    shift_amt;

  // Encrypt-direction rotate amount for round r (1-based).
  function automatic logic [1:0] enc_shift(input logic [4:0] r);
    case (r)
      5'd1, 5'd2, 5'd9, 5'd16: enc_shift = 2'd1;
      default:                 enc_shift = 2'd2;
    endcase
  endfunction

  // Decrypt walks the schedule backwards with right rotates; round 1 uses the
  // unrotated C0/D0 because the 28 total left shifts return to the start.
  assign shift_amt = mode ? ((rnd_cnt == 5'd1) ? 2'd0 : enc_shift(5'd18 - rnd_cnt))
                          : enc_shift(rnd_cnt);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create ordering-dependent races.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode; outputs depend on registered state only.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    rnd_load  = 1'b0;
    rnd_en    = 1'b0;
    rnd_num   = '0;
    key_shift = '0;
    key_dir   = 1'b0;
    fp_start  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        rnd_load  = 1'b1;
        state_nxt = ROUND;
      end
      ROUND: begin
        rnd_en    = 1'b1;
        rnd_num   = rnd_cnt;
        key_shift = shift_amt;
        key_dir   = mode;
        if (rnd_cnt == ROUND_LAST) state_nxt = FP;
      end
      FP: begin
        fp_start  = 1'b1;
        state_nxt = WAIT_FP;
      end
      WAIT_FP: begin
        if (fp_ready)               state_nxt = DONE;
        else if (to_cnt == TO_LAST) state_nxt = IDLE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Mode latch, round/timeout counters, result capture, block counter, err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= 1'b0;
      rnd_cnt  <= '0;
      to_cnt   <= '0;
      out_data <= '0;
      blk_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE:  if (in_valid) mode <= in_decrypt;
        LOAD:  rnd_cnt <= 5'd1;
        ROUND: if (rnd_cnt != ROUND_LAST) rnd_cnt <= rnd_cnt + 5'd1;
        FP:    to_cnt <= '0;
        WAIT_FP: begin
          if (fp_ready) begin
            out_data <= fp_data;
            if (blk_cnt != 16'hFFFF) blk_cnt <= blk_cnt + 16'd1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
            if (to_cnt == TO_LAST) err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
